// File: rtl/inject_dispatch_if.sv
// Producer/router-facing bundle for the inject dispatcher: one input stream,
// six router inject ports, a local loopback and a busy flag.
interface inject_dispatch_if #(
    parameter int PayloadWidth = 32,
    parameter int lg_numprocs  = 3
);
    localparam int FlitChildWidth = PayloadWidth + 50 + lg_numprocs;

    logic [FlitChildWidth-1:0] in_flit;
    logic                      in_valid;
    logic                      in_ready;
    logic [5:0]                port_ready;
    logic [FlitChildWidth-1:0] inject_xpos;
    logic [FlitChildWidth-1:0] inject_ypos;
    logic [FlitChildWidth-1:0] inject_zpos;
    logic [FlitChildWidth-1:0] inject_xneg;
    logic [FlitChildWidth-1:0] inject_yneg;
    logic [FlitChildWidth-1:0] inject_zneg;
    logic [FlitChildWidth-1:0] local_out;
    logic                      local_valid;
    logic                      busy;

    // Producer / router side: drives the flit stream and per-port ready
    modport master (
        output in_flit, in_valid, port_ready,
        input  in_ready, inject_xpos, inject_ypos, inject_zpos,
               inject_xneg, inject_yneg, inject_zneg,
               local_out, local_valid, busy
    );

    // Dispatcher side
    modport slave (
        input  in_flit, in_valid, port_ready,
        output in_ready, inject_xpos, inject_ypos, inject_zpos,
               inject_xneg, inject_yneg, inject_zneg,
               local_out, local_valid, busy
    );
endinterface

// File: rtl/inject_dispatch.sv
// Transmit-side dispatcher: takes one stream of child-tagged flits, picks a
// torus direction by dimension-order routing (X, then Y, then Z, shortest
// way round), and queues each flit in a per-direction FIFO that drains into
// its router inject port. Flits addressed to this node loop back locally.
module inject_dispatch #(
    parameter logic [2:0] cur_x        = 3'd0,
    parameter logic [2:0] cur_y        = 3'd0,
    parameter logic [2:0] cur_z        = 3'd0,
    parameter int         lg_numprocs  = 3,
    parameter int         PayloadWidth = 32,
    parameter int         QDepth       = 4
) (
    input logic              clk,
    input logic              rst,
    inject_dispatch_if.slave bus
);
    localparam int FlitWidth      = PayloadWidth + 50;
    localparam int FlitChildWidth = FlitWidth + lg_numprocs;
    localparam int ValidBitPos    = PayloadWidth + 49;
    localparam int DstXLsb        = PayloadWidth + 40;
    localparam int DstYLsb        = PayloadWidth + 43;
    localparam int DstZLsb        = PayloadWidth + 46;
    localparam int PtrW           = $clog2(QDepth);
    localparam int CntW           = PtrW + 1;

    typedef enum logic [2:0] {
        TgtXpos  = 3'd0,
        TgtYpos  = 3'd1,
        TgtZpos  = 3'd2,
        TgtXneg  = 3'd3,
        TgtYneg  = 3'd4,
        TgtZneg  = 3'd5,
        TgtLocal = 3'd6
    } target_e;

    // A 3-bit modular difference of 1..4 is reached fastest going positive,
    // 5..7 going negative; a tie at 4 goes positive.
    function automatic target_e routeTarget(input logic [FlitChildWidth-1:0] flit);
        logic [2:0] dx;
        logic [2:0] dy;
        logic [2:0] dz;
        target_e    t;
        dx = flit[DstXLsb +: 3] - cur_x;
        dy = flit[DstYLsb +: 3] - cur_y;
        dz = flit[DstZLsb +: 3] - cur_z;
        if (dx != 3'd0) begin
            t = (dx <= 3'd4) ? TgtXpos : TgtXneg;
        end else if (dy != 3'd0) begin
            t = (dy <= 3'd4) ? TgtYpos : TgtYneg;
        end else if (dz != 3'd0) begin
            t = (dz <= 3'd4) ? TgtZpos : TgtZneg;
        end else begin
            t = TgtLocal;
        end
        return t;
    endfunction

    logic                      stageValid_q, stageValid_d;
    logic [FlitChildWidth-1:0] stageFlit_q,  stageFlit_d;
    target_e                   stageTarget_q, stageTarget_d;

    logic [7:0]                fullVec;
    logic [5:0]                pushVec;
    logic [5:0]                nonEmptyVec;
    logic                      stageBlocked;
    logic                      stageAdvance;
    logic                      acceptIn;
    logic                      toLocal;

    logic                      localValid_q;
    logic [FlitChildWidth-1:0] localOut_q;

    // Entries 6 and 7 of the full vector stand for the never-full loopback
    assign fullVec[7:6] = 2'b00;

    // Handshake: the stage frees up whenever its flit can move on this edge
    always_comb begin
        stageBlocked = fullVec[stageTarget_q];
        stageAdvance = stageValid_q && !stageBlocked;
        bus.in_ready = !stageValid_q || !stageBlocked;
        acceptIn     = bus.in_valid && bus.in_ready;
        toLocal      = stageAdvance && (stageTarget_q == TgtLocal);
    end

    // Stage next state: reload on accept (valid bit forced), empty on drain
    always_comb begin
        stageValid_d  = stageValid_q;
        stageFlit_d   = stageFlit_q;
        stageTarget_d = stageTarget_q;
        if (acceptIn) begin
            stageValid_d             = 1'b1;
            stageFlit_d              = bus.in_flit;
            stageFlit_d[ValidBitPos] = 1'b1;
            stageTarget_d            = routeTarget(bus.in_flit);
        end else if (stageAdvance) begin
            stageValid_d = 1'b0;
        end
    end

    // Stage register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stageValid_q  <= 1'b0;
            stageFlit_q   <= '0;
            stageTarget_q <= TgtXpos;
        end else begin
            stageValid_q  <= stageValid_d;
            stageFlit_q   <= stageFlit_d;
            stageTarget_q <= stageTarget_d;
        end
    end

    // Loopback: one registered cycle per local flit, no backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            localValid_q <= 1'b0;
            localOut_q   <= '0;
        end else begin
            localValid_q <= toLocal;
            localOut_q   <= toLocal ? stageFlit_q : '0;
        end
    end

    for (genvar p = 0; p < 6; p++) begin : fifoGen
        logic [FlitChildWidth-1:0] memQ [QDepth];
        logic [PtrW-1:0]           wrPtr_q;
        logic [PtrW-1:0]           rdPtr_q;
        logic [CntW-1:0]           count_q;
        logic [FlitChildWidth-1:0] injectFlit_q;
        logic                      popNow;

        assign pushVec[p]     = stageAdvance && (stageTarget_q == 3'(p));
        assign popNow         = (count_q != '0) && bus.port_ready[p];
        assign fullVec[p]     = (count_q == CntW'(QDepth));
        assign nonEmptyVec[p] = (count_q != '0);

        // Storage write; contents need no reset since the count guards them
        always_ff @(posedge clk) begin
            if (pushVec[p]) begin
                memQ[wrPtr_q] <= stageFlit_q;
            end
        end

        // Pointers wrap naturally at the power-of-two depth
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                count_q <= '0;
            end else begin
                if (pushVec[p]) begin
                    wrPtr_q <= wrPtr_q + PtrW'(1);
                end
                if (popNow) begin
                    rdPtr_q <= rdPtr_q + PtrW'(1);
                end
                count_q <= count_q + CntW'(pushVec[p]) - CntW'(popNow);
            end
        end

        // Inject register shows a popped flit for exactly one cycle, else zero
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                injectFlit_q <= '0;
            end else begin
                injectFlit_q <= popNow ? memQ[rdPtr_q] : '0;
            end
        end
    end

    assign bus.inject_xpos = fifoGen[0].injectFlit_q;
    assign bus.inject_ypos = fifoGen[1].injectFlit_q;
    assign bus.inject_zpos = fifoGen[2].injectFlit_q;
    assign bus.inject_xneg = fifoGen[3].injectFlit_q;
    assign bus.inject_yneg = fifoGen[4].injectFlit_q;
    assign bus.inject_zneg = fifoGen[5].injectFlit_q;
    assign bus.local_out   = localOut_q;
    assign bus.local_valid = localValid_q;
    assign bus.busy        = stageValid_q || (|nonEmptyVec);
endmodule
